// File: rtl/uart_wb_host_if.sv
// Wishbone-style register port between uart_wb_host (master) and the uart slave pins.
interface uart_wb_host_if;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic [7:0] wb_data_in;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_ack;

    modport master (
        output wb_addr, wb_data_out, wb_we, wb_stb,
        input  wb_data_in, wb_ack
    );

    modport slave (
        input  wb_addr, wb_data_out, wb_we, wb_stb,
        output wb_data_in, wb_ack
    );
endinterface

// File: rtl/uart_wb_host.sv
// Byte-stream to uart register-port initiator: polls status, writes held TX bytes,
// reads RX bytes, and aborts bus cycles that are never acknowledged.
module uart_wb_host #(
    parameter int unsigned POLL_INTERVAL = 64,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [7:0]     tx_data,
    input  logic           tx_valid,
    output logic           tx_ready,
    output logic [7:0]     rx_data,
    output logic           rx_valid,
    output logic           bus_err,
    output logic [2:0]     dbg_state_o,
    uart_wb_host_if.master wb
);
    localparam logic [15:0] POLL_RELOAD = 16'(POLL_INTERVAL - 1);
    localparam logic [15:0] TO_LAST     = 16'(ACK_TIMEOUT - 1);
    localparam logic [1:0]  A_TXD  = 2'd0;
    localparam logic [1:0]  A_STAT = 2'd1;
    localparam logic [1:0]  A_RXD  = 2'd2;

    // S_DEC is the mandatory strobe-low cycle after a status read; it also decodes the result.
    typedef enum logic [2:0] {S_IDLE, S_STAT, S_DEC, S_TXW, S_RXR} state_e;

    state_e      state_q, state_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_full_q, hold_full_d;
    logic [1:0]  status_q, status_d;
    logic        rx_pend_q, rx_pend_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        bus_err_q, bus_err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            hold_data_q <= 8'h00;
            hold_full_q <= 1'b0;
            status_q    <= 2'b00;
            rx_pend_q   <= 1'b0;
            poll_cnt_q  <= POLL_RELOAD;
            to_cnt_q    <= 16'd0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 2'd0;
            wdata_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            status_q    <= status_d;
            rx_pend_q   <= rx_pend_d;
            poll_cnt_q  <= poll_cnt_d;
            to_cnt_q    <= to_cnt_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Stream handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
    // tx_ready is low from the accepting edge until the edge that completes its TX write.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        status_d    = status_q;
        rx_pend_d   = rx_pend_q;
        poll_cnt_d  = poll_cnt_q;
        to_cnt_d    = to_cnt_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        bus_err_d   = 1'b0;

        if (tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end

        unique case (state_q)
            S_IDLE: begin
                if (hold_full_q || rx_pend_q || (poll_cnt_q == 16'd0)) begin
                    state_d    = S_STAT;
                    stb_d      = 1'b1;
                    addr_d     = A_STAT;
                    we_d       = 1'b0;
                    to_cnt_d   = 16'd0;
                    poll_cnt_d = POLL_RELOAD;
                    rx_pend_d  = 1'b0;
                end else begin
                    poll_cnt_d = poll_cnt_q - 16'd1;
                end
            end
            S_DEC: begin
                to_cnt_d = 16'd0;
                if (hold_full_q && !status_q[0]) begin
                    state_d = S_TXW;
                    stb_d   = 1'b1;
                    addr_d  = A_TXD;
                    we_d    = 1'b1;
                    wdata_d = hold_data_q;
                end else if (status_q[1]) begin
                    state_d = S_RXR;
                    stb_d   = 1'b1;
                    addr_d  = A_RXD;
                    we_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STAT, S_TXW, S_RXR: begin
                if (wb.wb_ack) begin
                    stb_d = 1'b0;
                    if (state_q == S_STAT) begin
                        status_d = wb.wb_data_in[1:0];
                        state_d  = S_DEC;
                    end else if (state_q == S_TXW) begin
                        hold_full_d = 1'b0;
                        rx_pend_d   = status_q[1];
                        state_d     = S_IDLE;
                    end else begin
                        rx_data_d  = wb.wb_data_in;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    // Abandon the cycle; a held byte stays put and is retried from IDLE.
                    stb_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    assign tx_ready       = !hold_full_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign bus_err        = bus_err_q;
    assign dbg_state_o    = state_q;
    assign wb.wb_stb      = stb_q;
    assign wb.wb_we       = we_q;
    assign wb.wb_addr     = addr_q;
    assign wb.wb_data_out = wdata_q;
endmodule

// File: tb/tb_uart_wb_host.sv
// Bench for uart_wb_host: a small uart register-slave model, a bus/rx monitor, and
// one task per scenario comparing observed bus traffic against a scoreboard.
module tb_uart_wb_host;
    localparam int POLL = 16;
    localparam int ATO  = 4;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       bus_err;
    logic [2:0] dbg_state;

    uart_wb_host_if wb();

    uart_wb_host #(.POLL_INTERVAL(POLL), .ACK_TIMEOUT(ATO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .bus_err     (bus_err),
        .dbg_state_o (dbg_state),
        .wb          (wb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] addr;
        logic       we;
        logic [7:0] data;
    } bus_rec_t;

    bus_rec_t   bus_log_q[$];
    logic [7:0] rx_log_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_rx_q[$];

    int         err_cnt    = 0;
    int         stat_seen  = 0;
    int         rx_reads   = 0;
    int         busy_until = 0;
    int         rx_posts   = 0;
    logic       ack_en     = 1'b1;
    logic [7:0] rx_byte    = 8'h00;
    int         checks     = 0;
    int         failures   = 0;

    // Slave model: status busy for a set number of reads, rx_avail until the RX reg is read.
    logic slv_busy, slv_rxav;
    always_comb begin
        slv_busy      = (stat_seen < busy_until);
        slv_rxav      = (rx_reads < rx_posts);
        wb.wb_ack     = wb.wb_stb && ack_en;
        wb.wb_data_in = 8'h00;
        case (wb.wb_addr)
            2'd1:    wb.wb_data_in = {6'd0, slv_rxav, slv_busy};
            2'd2:    wb.wb_data_in = rx_byte;
            default: wb.wb_data_in = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (wb.wb_stb && wb.wb_ack && !wb.wb_we) begin
            if (wb.wb_addr == 2'd1) stat_seen <= stat_seen + 1;
            if (wb.wb_addr == 2'd2) rx_reads  <= rx_reads + 1;
        end
    end

    always @(negedge clk) begin
        if (wb.wb_stb && wb.wb_ack) bus_log_q.push_back({wb.wb_addr, wb.wb_we, wb.wb_data_out});
        if (rx_valid) rx_log_q.push_back(rx_data);
        if (bus_err) err_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        tx_valid   = 1'b0;
        ack_en     = 1'b1;
        busy_until = stat_seen;
        rx_posts   = rx_reads;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        checks++; if (wb.wb_stb !== 1'b0) begin failures++; $display("FAIL reset_stb: got %b want 0", wb.wb_stb); end
        checks++; if (wb.wb_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", wb.wb_we); end
        checks++; if (wb.wb_addr !== 2'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", wb.wb_addr); end
        checks++; if (wb.wb_data_out !== 8'h00) begin failures++; $display("FAIL reset_wdata: got %h want 00", wb.wb_data_out); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_single_byte();
        int base, low;
        bus_rec_t r;
        apply_reset();
        base = bus_log_q.size();
        tx_data = 8'h41; tx_valid = 1'b1; exp_q.push_back(8'h41);
        step();
        tx_valid = 1'b0;
        low = 0;
        while (!tx_ready && low < 50) begin low++; step(); end
        checks++; if (low != 4) begin failures++; $display("FAIL single_ready_low: got %0d cycles want 4", low); end
        checks++;
        if (bus_log_q.size() - base != 2) begin
            failures++; $display("FAIL single_bus_count: got %0d cycles want 2", bus_log_q.size() - base);
        end else begin
            r = bus_log_q[base];
            checks++; if (r.addr !== 2'd1 || r.we !== 1'b0) begin failures++; $display("FAIL single_stat: got addr=%0d we=%b want addr=1 we=0", r.addr, r.we); end
            r = bus_log_q[base + 1];
            checks++; if (r.addr !== 2'd0 || r.we !== 1'b1) begin failures++; $display("FAIL single_txw: got addr=%0d we=%b want addr=0 we=1", r.addr, r.we); end
        end
        for (int i = base; i < bus_log_q.size(); i++) begin
            if (bus_log_q[i].we) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL single_extra_write: got %h want none", bus_log_q[i].data); end
                else begin
                    r.data = exp_q.pop_front();
                    if (bus_log_q[i].data !== r.data) begin failures++; $display("FAIL single_data: got %h want %h", bus_log_q[i].data, r.data); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_missing: got %0d unwritten want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_busy_polls();
        int base, n, stats_before, writes;
        logic [7:0] e;
        apply_reset();
        busy_until = stat_seen + 3;
        base = bus_log_q.size();
        tx_data = 8'h41; tx_valid = 1'b1; exp_q.push_back(8'h41);
        step();
        tx_valid = 1'b0;
        n = 0;
        while (!tx_ready && n < 200) begin n++; step(); end
        checks++; if (!tx_ready) begin failures++; $display("FAIL busy_ready_timeout: got tx_ready=0 want 1"); end
        stats_before = 0; writes = 0;
        for (int i = base; i < bus_log_q.size(); i++) begin
            if (bus_log_q[i].we) begin
                writes++;
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL busy_extra_write: got %h want none", bus_log_q[i].data); end
                else begin
                    e = exp_q.pop_front();
                    if (bus_log_q[i].data !== e) begin failures++; $display("FAIL busy_data: got %h want %h", bus_log_q[i].data, e); end
                end
            end else if (writes == 0 && bus_log_q[i].addr == 2'd1) stats_before++;
        end
        checks++; if (stats_before != 4) begin failures++; $display("FAIL busy_stat_reads: got %0d want 4", stats_before); end
        checks++; if (writes != 1) begin failures++; $display("FAIL busy_write_count: got %0d want 1", writes); end
        exp_q.delete();
    endtask

    task automatic test_rx_poll();
        int base, rbase, n;
        logic [7:0] e;
        apply_reset();
        rx_byte = 8'h5A; rx_posts = rx_reads + 1; exp_rx_q.push_back(8'h5A);
        base = bus_log_q.size(); rbase = rx_log_q.size();
        n = 0;
        while (!wb.wb_stb && n < POLL + 8) begin n++; step(); end
        checks++; if (n > POLL || n == 0) begin failures++; $display("FAIL rx_first_poll: got %0d cycles want 1..%0d", n, POLL); end
        n = 0;
        while (rx_log_q.size() == rbase && n < 20) begin n++; step(); end
        repeat (5) step();
        checks++; if (rx_log_q.size() - rbase != 1) begin failures++; $display("FAIL rx_pulse_count: got %0d want 1", rx_log_q.size() - rbase); end
        if (rx_log_q.size() > rbase) begin
            e = exp_rx_q.pop_front();
            checks++; if (rx_log_q[rbase] !== e) begin failures++; $display("FAIL rx_data: got %h want %h", rx_log_q[rbase], e); end
        end
        exp_rx_q.delete();
        checks++;
        if (bus_log_q.size() - base < 2) begin failures++; $display("FAIL rx_bus_count: got %0d want >=2", bus_log_q.size() - base); end
        else if (bus_log_q[base].addr !== 2'd1 || bus_log_q[base + 1].addr !== 2'd2 || bus_log_q[base + 1].we !== 1'b0) begin
            failures++; $display("FAIL rx_sequence: got addr %0d,%0d want 1,2", bus_log_q[base].addr, bus_log_q[base + 1].addr);
        end
        checks++; if (rx_data !== 8'h5A || rx_valid !== 1'b0) begin failures++; $display("FAIL rx_hold: got data=%h valid=%b want 5a/0", rx_data, rx_valid); end
    endtask

    task automatic test_tx_rx_priority();
        int base, rbase, n;
        logic [7:0] e;
        apply_reset();
        rx_byte = 8'h33; rx_posts = rx_reads + 1; exp_rx_q.push_back(8'h33);
        base = bus_log_q.size(); rbase = rx_log_q.size();
        tx_data = 8'hC3; tx_valid = 1'b1; exp_q.push_back(8'hC3);
        step();
        tx_valid = 1'b0;
        n = 0;
        while (!tx_ready && n < 50) begin n++; step(); end
        n = 0;
        while (rx_log_q.size() == rbase && n < 6) begin n++; step(); end
        checks++; if (rx_log_q.size() == rbase) begin failures++; $display("FAIL prio_rx_latency: got no rx within 6 cycles want rx"); end
        else begin
            e = exp_rx_q.pop_front();
            checks++; if (rx_log_q[rbase] !== e) begin failures++; $display("FAIL prio_rx_data: got %h want %h", rx_log_q[rbase], e); end
        end
        exp_rx_q.delete();
        checks++;
        if (bus_log_q.size() - base < 4) begin failures++; $display("FAIL prio_bus_count: got %0d want 4", bus_log_q.size() - base); end
        else begin
            if (bus_log_q[base].addr !== 2'd1 || bus_log_q[base + 1].addr !== 2'd0 || bus_log_q[base + 1].we !== 1'b1 ||
                bus_log_q[base + 2].addr !== 2'd1 || bus_log_q[base + 3].addr !== 2'd2) begin
                failures++;
                $display("FAIL prio_sequence: got addr %0d,%0d,%0d,%0d want 1,0,1,2", bus_log_q[base].addr,
                         bus_log_q[base + 1].addr, bus_log_q[base + 2].addr, bus_log_q[base + 3].addr);
            end
            e = exp_q.pop_front();
            checks++; if (bus_log_q[base + 1].data !== e) begin failures++; $display("FAIL prio_tx_data: got %h want %h", bus_log_q[base + 1].data, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_timeout();
        int base, ebase, n, hi, writes;
        logic [7:0] e;
        apply_reset();
        ack_en = 1'b0;
        base = bus_log_q.size();
        tx_data = 8'h99; tx_valid = 1'b1; exp_q.push_back(8'h99);
        step();
        tx_valid = 1'b0;
        ebase = err_cnt;
        n = 0;
        while (!wb.wb_stb && n < 10) begin n++; step(); end
        hi = 0;
        while (wb.wb_stb && hi < 20) begin hi++; step(); end
        checks++; if (hi != ATO) begin failures++; $display("FAIL to_stb_len: got %0d cycles want %0d", hi, ATO); end
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL to_bus_err: got %b want 1", bus_err); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL to_tx_ready: got %b want 0", tx_ready); end
        step();
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_err_pulse: got %b want 0", bus_err); end
        ack_en = 1'b1;
        n = 0;
        while (!tx_ready && n < 50) begin n++; step(); end
        step();
        checks++; if (err_cnt - ebase != 1) begin failures++; $display("FAIL to_err_count: got %0d want 1", err_cnt - ebase); end
        writes = 0;
        for (int i = base; i < bus_log_q.size(); i++) begin
            if (bus_log_q[i].we) begin
                writes++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++; if (bus_log_q[i].data !== e) begin failures++; $display("FAIL to_data: got %h want %h", bus_log_q[i].data, e); end
                end
            end
        end
        checks++; if (writes != 1) begin failures++; $display("FAIL to_write_count: got %0d want 1", writes); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_txw();
        int base, n, writes;
        apply_reset();
        tx_data = 8'h77; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        n = 0;
        while (!(wb.wb_stb && wb.wb_we) && n < 20) begin n++; step(); end
        checks++; if (!(wb.wb_stb && wb.wb_we)) begin failures++; $display("FAIL rst_no_txw: got stb=%b we=%b want 1/1", wb.wb_stb, wb.wb_we); end
        base = bus_log_q.size();
        reset_n = 1'b0;
        #1;
        checks++; if (wb.wb_stb !== 1'b0) begin failures++; $display("FAIL rst_async_stb: got %b want 0", wb.wb_stb); end
        step(); step();
        reset_n = 1'b1;
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
        repeat (3 * POLL) step();
        writes = 0;
        for (int i = base; i < bus_log_q.size(); i++) if (bus_log_q[i].we) writes++;
        checks++; if (writes != 0) begin failures++; $display("FAIL rst_write_count: got %0d want 0", writes); end
    endtask

    task automatic test_back_to_back();
        int base, low;
        logic [7:0] d[4];
        logic [7:0] e;
        apply_reset();
        base = bus_log_q.size();
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_before_%0d: got %b want 1", i, tx_ready); end
            tx_data = d[i]; tx_valid = 1'b1; exp_q.push_back(d[i]);
            step();
            low = 0;
            while (!tx_ready && low < 50) begin low++; step(); end
            checks++; if (low != 4) begin failures++; $display("FAIL b2b_ready_low_%0d: got %0d cycles want 4", i, low); end
        end
        tx_valid = 1'b0;
        repeat (2) step();
        for (int i = base; i < bus_log_q.size(); i++) begin
            if (bus_log_q[i].we) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra_write: got %h want none", bus_log_q[i].data); end
                else begin
                    e = exp_q.pop_front();
                    if (bus_log_q[i].data !== e) begin failures++; $display("FAIL b2b_data: got %h want %h", bus_log_q[i].data, e); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing: got %0d unwritten want 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_busy_polls();
        test_rx_poll();
        test_tx_rx_priority();
        test_timeout();
        test_reset_mid_txw();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_wb_host.md
# uart_wb_host

Bus initiator that drives the uart block's 8-bit register port from the system clock domain. It accepts bytes on a valid/ready stream and writes each one to the uart TX data register once the status register reports the transmitter idle. It also polls for received bytes and returns them as a one-cycle strobe. It sits between a byte-stream producer/consumer and the uart's wb_* slave pins, replacing hand-driven stimulus on that port.

## Interface
- POLL_INTERVAL, 64: clk cycles between idle status polls; range 2..65535.
- ACK_TIMEOUT, 255: clk cycles a strobe may wait for wb_ack before abort; range 1..65535.
- clk  in  1  single system clock; also drives the uart wb_clk.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  host can accept a byte this cycle.
- rx_data  out  8  last byte read from the uart; held until the next read.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- bus_err  out  1  one-cycle pulse; a bus cycle timed out.
- wb_addr  out  2  register address: 0 = TX data (write), 1 = status (read), 2 = RX data (read).
- wb_data_out  out  8  write data; connects to uart wb_data_in.
- wb_data_in  in  8  read data; connects to uart wb_data_out. Status bit0 = tx_busy, bit1 = rx_avail.
- wb_we  out  1  1 = write cycle.
- wb_stb  out  1  cycle strobe; connects to uart wb_stb.
- wb_ack  in  1  slave acknowledge.

## Operation
- Holding register: 8-bit hold_data plus hold_full flag.
  - tx_ready = !hold_full.
  - tx_valid && tx_ready at a rising edge loads hold_data and sets hold_full.
  - hold_full clears only when the TX write is acked.
- Poll counter: counts down from POLL_INTERVAL-1 in IDLE. A status read starts when either hold_full is set or the counter reaches 0. The counter reloads on every exit from IDLE.
- States:
  - IDLE -> STAT when a status read starts.
  - STAT: strobe on, addr=1, we=0. When acked, register status, then:
    - to TXW if hold_full && !tx_busy;
    - else to RXR if rx_avail;
    - else to IDLE.
  - TXW: strobe on, addr=0, we=1, data=hold_data. When acked, clear hold_full and go to IDLE.
  - RXR: strobe on, addr=2, we=0. When acked, capture rx_data, pulse rx_valid, go to IDLE.
- TX takes priority over RX within one status result. A pending RX byte is picked up on the next poll, which starts immediately because of the rule below.
- After TXW, if the latched status had rx_avail=1, the next IDLE cycle starts STAT without waiting for the poll counter.
- Timeout: a per-cycle counter counts clk cycles with wb_stb high and no ack. When it reaches ACK_TIMEOUT:
  - drop wb_stb, pulse bus_err, go to IDLE;
  - hold_full and hold_data are unchanged, so the byte is retried.
- The host has at most one bus cycle outstanding. wb_addr, wb_we and wb_data_out are stable for the whole time wb_stb is high.

## Timing
- All outputs are registered.
- Reset values: tx_ready=1 (after reset, hold_full=0), rx_data=0, rx_valid=0, bus_err=0, wb_stb=0, wb_we=0, wb_addr=0, wb_data_out=0. State=IDLE, poll counter=POLL_INTERVAL-1.
- Asserting reset_n=0 mid-cycle drops wb_stb immediately (asynchronously) and discards a held byte. The uart sees an abandoned strobe; this is acceptable.
- wb_stb rises on the edge that enters a bus state.
- wb_ack is sampled on each rising edge while wb_stb is high. The edge that samples ack=1 drops wb_stb and moves the state.
- wb_stb is low for at least one cycle between consecutive bus cycles. An ack arriving while wb_stb is low is ignored.
- Best-case accept-to-write latency, with ack returned the first cycle of each strobe: tx accept at edge k; STAT strobe during k+1; idle gap; TXW strobe at k+3; hold_full clears at edge k+4, so tx_ready returns high after edge k+4.
- rx_valid is high for exactly the one cycle after the RXR ack edge.
- If tx_valid is asserted in the same cycle that hold_full clears, the byte is not accepted, because tx_ready was 0 that cycle.

## Test plan
- Single byte 0x41, slave acks the first cycle: the bus shows STAT read, then a TXW write with wb_data_out=0x41 at addr 0. tx_ready is low 4 cycles, then high.
- Slave returns tx_busy=1 for 3 polls: no TXW is issued. After the first status read with tx_busy=0, exactly one write of 0x41 occurs.
- Idle host, slave status rx_avail=1, RX reg 0x5A: the first read occurs within POLL_INTERVAL cycles after reset. It is followed by a read of addr 2, then rx_data=0x5A with a single rx_valid pulse.
- Status 0x02 with hold_full=1 (tx_busy=0, rx_avail=1): TXW occurs before RXR. RXR follows after exactly one STAT, with no wait for the poll interval.
- Slave never acks, ACK_TIMEOUT=4: wb_stb is high 4 cycles, then bus_err pulses once and tx_ready stays 0. After acks are re-enabled, the byte is written once.
- reset_n pulsed low while the TXW strobe is high: wb_stb=0 asynchronously, tx_ready=1 after release, and no write is issued.
